// File: rtl/div_32.sv
// Signed 32-bit restoring divider that borrows the shared carry-lookahead adder for
// every negation and trial subtraction; quotient truncates toward zero, fixed latency.
module div_32 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic [31:0] add_A,
    output logic [31:0] add_B,
    output logic        add_Cin,
    output logic [31:0] add_A_and_B,
    output logic [31:0] add_A_or_B,
    input  logic [31:0] add_S,
    input  logic        add_Cout
);

    typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, ITER, FIX, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [5:0]  r_cnt;
    logic        r_neg;
    logic        r_exc;
    logic [31:0] r_result;

    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic        w_add_cin;
    logic [31:0] w_rs;
    logic [31:0] w_qs;
    logic        w_div_zero;

    // {R,Q} shifted left by one; R < D <= 2^31 so the shifted remainder never overflows
    assign w_rs       = {r_rem[30:0], r_quo[31]};
    assign w_qs       = {r_quo[30:0], 1'b0};
    assign w_div_zero = (data_operandB == 32'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_add_a      = 32'd0;
        w_add_b      = 32'd0;
        w_add_cin    = 1'b0;
        case (r_state)
            ABS_A: begin
                w_add_b      = ~r_quo;
                w_add_cin    = 1'b1;
                w_state_next = ABS_B;
            end
            ABS_B: begin
                w_add_b      = ~r_div;
                w_add_cin    = 1'b1;
                w_state_next = ITER;
            end
            ITER: begin
                w_add_a   = w_rs;
                w_add_b   = ~r_div;
                w_add_cin = 1'b1;
                if (r_cnt == 6'd31) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_add_b      = ~r_quo;
                w_add_cin    = 1'b1;
                w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        // A start always wins, including over an operation in flight
        if (ctrl_DIV) begin
            w_state_next = w_div_zero ? DONE : ABS_A;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_div    <= 32'd0;
            r_cnt    <= 6'd0;
            r_neg    <= 1'b0;
            r_exc    <= 1'b0;
            r_result <= 32'd0;
        end else if (ctrl_DIV) begin
            if (w_div_zero) begin
                r_result <= 32'd0;
                r_exc    <= 1'b1;
            end else begin
                r_quo <= data_operandA;
                r_div <= data_operandB;
                r_neg <= data_operandA[31] ^ data_operandB[31];
                r_rem <= 32'd0;
            end
        end else begin
            case (r_state)
                ABS_A: begin
                    if (r_quo[31]) begin
                        r_quo <= add_S;
                    end
                end
                ABS_B: begin
                    if (r_div[31]) begin
                        r_div <= add_S;
                    end
                    r_cnt <= 6'd0;
                end
                ITER: begin
                    // Carry-out of Rs + ~D + 1 means Rs >= D
                    if (add_Cout) begin
                        r_rem <= add_S;
                        r_quo <= w_qs | 32'd1;
                    end else begin
                        r_rem <= w_rs;
                        r_quo <= w_qs;
                    end
                    r_cnt <= r_cnt + 6'd1;
                end
                FIX: begin
                    r_result <= r_neg ? add_S : r_quo;
                    r_exc    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign add_A          = w_add_a;
    assign add_B          = w_add_b;
    assign add_Cin        = w_add_cin;
    assign add_A_and_B    = w_add_a & w_add_b;
    assign add_A_or_B     = w_add_a | w_add_b;
    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == DONE);

endmodule

// File: tb/tb_div_32.sv
// Bench for div_32: models the external adder, runs a fixed vector table, random
// operands against an arithmetic reference, and restart/reset/back-to-back sequences.
module tb_div_32;

    logic        clock;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [31:0] add_A;
    logic [31:0] add_B;
    logic        add_Cin;
    logic [31:0] add_A_and_B;
    logic [31:0] add_A_or_B;
    logic [31:0] add_S;
    logic        add_Cout;

    int vectors;
    int miscompares;

    div_32 dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .add_A          (add_A),
        .add_B          (add_B),
        .add_Cin        (add_Cin),
        .add_A_and_B    (add_A_and_B),
        .add_A_or_B     (add_A_or_B),
        .add_S          (add_S),
        .add_Cout       (add_Cout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // The shared carry-lookahead adder, as a plain 33-bit sum
    assign {add_Cout, add_S} = {1'b0, add_A} + {1'b0, add_B} + {32'd0, add_Cin};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            check("add_and", add_A_and_B, add_A & add_B);
            check("add_or", add_A_or_B, add_A | add_B);
        end
    end

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic e);
        longint sa;
        longint sb;
        longint sq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = 32'd0;
            e = 1'b1;
        end else begin
            sq = sa / sb;
            q  = sq[31:0];
            e  = 1'b0;
        end
    endfunction

    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
    endtask

    // Cycles from E0 until RDY is seen; -1 if it never comes
    task automatic wait_rdy(output int lat);
        lat = 0;
        while (!data_resultRDY && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!data_resultRDY) lat = -1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_q,
                          input logic exp_e, input bit tail, input string nm);
        int lat;
        do_start(a, b);
        wait_rdy(lat);
        check({nm, "_latency"}, 32'(lat), (b == 32'd0) ? 32'd0 : 32'd35);
        if (lat >= 0) begin
            check({nm, "_result"}, data_result, exp_q);
            check({nm, "_exc"}, {31'd0, data_exception}, {31'd0, exp_e});
            if (tail) begin
                @(posedge clock);
                #1;
                check({nm, "_rdy_one_cycle"}, {31'd0, data_resultRDY}, 32'd0);
                check({nm, "_hold"}, data_result, exp_q);
            end
        end
        $display("op %s: %h / %h -> %h exc=%0b latency=%0d", nm, a, b, data_result, data_exception, lat);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        e;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int          rdy_seen;
        int          lat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rq;
        logic        re;

        vectors     = 0;
        miscompares = 0;

        tbl[0]  = '{32'd100,        32'd7,          32'd14,         1'b0};
        tbl[1]  = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   1'b0};
        tbl[2]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         1'b0};
        tbl[3]  = '{32'd5,          32'd9,          32'd0,          1'b0};
        tbl[4]  = '{32'd7,          32'd0,          32'd0,          1'b1};
        tbl[5]  = '{32'd9,          32'd3,          32'd3,          1'b0};
        tbl[6]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0};
        tbl[7]  = '{32'h80000000,   32'd1,          32'h80000000,   1'b0};
        tbl[8]  = '{32'h7FFFFFFF,   32'h80000000,   32'd0,          1'b0};
        tbl[9]  = '{32'hFFFFFFFF,   32'h7FFFFFFF,   32'd0,          1'b0};
        tbl[10] = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0};
        tbl[11] = '{32'h80000000,   32'h80000000,   32'd1,          1'b0};
        tbl[12] = '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   1'b0};

        reset_n       = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_add_b", add_B, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].e, 1'b1, $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 120; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 20);
                2:       rb = 32'd0 - 32'($urandom_range(1, 300));
                default: rb = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            ref_div(ra, rb, rq, re);
            run_op(ra, rb, rq, re, 1'b1, $sformatf("rnd%0d", i));
        end

        // Start on the DONE->IDLE edge, after both a normal and a zero-divisor result
        run_op(32'd77, 32'd7, 32'd11, 1'b0, 1'b0, "b2b_first");
        run_op(32'd7, 32'd0, 32'd0, 1'b1, 1'b0, "b2b_zero");
        run_op(32'd9, 32'd3, 32'd3, 1'b0, 1'b1, "b2b_after_zero");

        // Restart at E10: single RDY 35 cycles after the second start
        do_start(32'd1000, 32'd3);
        rdy_seen = 0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        check("restart_no_early_rdy", 32'(rdy_seen), 32'd0);
        run_op(32'd50, 32'd5, 32'd10, 1'b0, 1'b1, "restart");

        // Asynchronous reset between E12 and E13
        do_start(32'd1000, 32'd3);
        repeat (12) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_result", data_result, 32'd0);
        check("midreset_exc", {31'd0, data_exception}, 32'd0);
        check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("midreset_add_a", add_A, 32'd0);
        check("midreset_add_b", add_B, 32'd0);
        check("midreset_add_cin", {31'd0, add_Cin}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n  = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        check("midreset_no_rdy", 32'(rdy_seen), 32'd0);
        run_op(32'd1000, 32'd3, 32'd333, 1'b0, 1'b1, "after_reset");

        // A held start keeps restarting; the final sample sets the result
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd500;
        data_operandB = 32'd9;
        repeat (3) @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        wait_rdy(lat);
        check("held_start_latency", 32'(lat), 32'd35);
        check("held_start_result", data_result, 32'd55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
